// File: rtl/snake_object_module_if.sv
// Bundle of pixel-query, control and status signals between the snake game-state
// holder and its drivers (tick/keypad logic and the VGA controller).
`timescale 1ns/1ps
interface snake_object_module_if;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       step;
    logic [1:0] dir;
    logic       grow;
    logic [1:0] object;
    logic [5:0] head_x;
    logic [4:0] head_y;
    logic [5:0] length;
    logic       dead;

    modport master (
        output pixel_x, pixel_y, step, dir, grow,
        input  object, head_x, head_y, length, dead
    );

    modport slave (
        input  pixel_x, pixel_y, step, dir, grow,
        output object, head_x, head_y, length, dead
    );
endinterface

// File: rtl/snake_object_module.sv
// Snake game state on a 40x30 cell grid plus registered per-pixel object classification.
// Optional macro SNAKE_WRAP_EN: no wall cells, head wraps at the grid border.
`timescale 1ns/1ps
module snake_object_module #(
    parameter int MAX_LEN = 16,
    parameter int INIT_X  = 20,
    parameter int INIT_Y  = 15
) (
    input logic                  clk_25mhz,
    input logic                  rst,
    snake_object_module_if.slave bus
);

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    localparam logic [1:0] OBJ_NONE = 2'b00;
    localparam logic [1:0] OBJ_HEAD = 2'b01;
    localparam logic [1:0] OBJ_BODY = 2'b10;
    localparam logic [1:0] OBJ_WALL = 2'b11;

    logic [5:0] seg_x_q [MAX_LEN];
    logic [4:0] seg_y_q [MAX_LEN];
    logic [5:0] seg_x_d [MAX_LEN];
    logic [4:0] seg_y_d [MAX_LEN];
    logic [5:0] length_q, length_d;
    logic [1:0] heading_q, heading_d;
    logic       grow_pend_q, grow_pend_d;
    logic       dead_q, dead_d;
    logic [1:0] object_q, object_d;

    logic       grow_ok_s;
    logic       grow_eff_s;
    logic [1:0] heading_new_s;
    logic [5:0] next_x_s;
    logic [4:0] next_y_s;
    logic       wall_hit_s;
    logic       body_hit_s;
    logic [5:0] body_lim_s;
    logic [5:0] cell_x_s;
    logic [5:0] cell_y_s;
    logic       in_range_s;
    logic       head_pix_s;
    logic       body_pix_s;
    logic       wall_pix_s;

    // Next head position, collision detection and segment/length/flag updates.
    always_comb begin
        grow_ok_s     = bus.grow && (length_q < 6'(MAX_LEN));
        grow_eff_s    = grow_pend_q || grow_ok_s;
        // The exact opposite of a heading differs only in bit 0.
        if (bus.dir == (heading_q ^ 2'b01)) begin
            heading_new_s = heading_q;
        end else begin
            heading_new_s = bus.dir;
        end

        next_x_s = seg_x_q[0];
        next_y_s = seg_y_q[0];
        case (heading_new_s)
`ifdef SNAKE_WRAP_EN
            DIR_UP:    next_y_s = (seg_y_q[0] == 5'd0)  ? 5'd29 : seg_y_q[0] - 5'd1;
            DIR_DOWN:  next_y_s = (seg_y_q[0] == 5'd29) ? 5'd0  : seg_y_q[0] + 5'd1;
            DIR_LEFT:  next_x_s = (seg_x_q[0] == 6'd0)  ? 6'd39 : seg_x_q[0] - 6'd1;
            DIR_RIGHT: next_x_s = (seg_x_q[0] == 6'd39) ? 6'd0  : seg_x_q[0] + 6'd1;
`else
            DIR_UP:    next_y_s = seg_y_q[0] - 5'd1;
            DIR_DOWN:  next_y_s = seg_y_q[0] + 5'd1;
            DIR_LEFT:  next_x_s = seg_x_q[0] - 6'd1;
            DIR_RIGHT: next_x_s = seg_x_q[0] + 6'd1;
`endif
            default: begin
                next_x_s = seg_x_q[0];
                next_y_s = seg_y_q[0];
            end
        endcase

`ifdef SNAKE_WRAP_EN
        wall_hit_s = 1'b0;
`else
        wall_hit_s = (next_x_s == 6'd0) || (next_x_s == 6'd39) ||
                     (next_y_s == 5'd0) || (next_y_s == 5'd29);
`endif

        // The tail cell only stays occupied when the snake is about to grow.
        body_lim_s = grow_eff_s ? (length_q - 6'd1) : (length_q - 6'd2);
        body_hit_s = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            body_hit_s = body_hit_s | ((6'(i) <= body_lim_s) &&
                                       (seg_x_q[i] == next_x_s) &&
                                       (seg_y_q[i] == next_y_s));
        end

        for (int i = 0; i < MAX_LEN; i++) begin
            seg_x_d[i] = seg_x_q[i];
            seg_y_d[i] = seg_y_q[i];
        end
        length_d    = length_q;
        heading_d   = heading_q;
        grow_pend_d = grow_pend_q || grow_ok_s;
        dead_d      = dead_q;

        if (bus.step && !dead_q) begin
            heading_d = heading_new_s;
            if (wall_hit_s || body_hit_s) begin
                dead_d = 1'b1;
            end else begin
                for (int i = 1; i < MAX_LEN; i++) begin
                    seg_x_d[i] = seg_x_q[i-1];
                    seg_y_d[i] = seg_y_q[i-1];
                end
                seg_x_d[0] = next_x_s;
                seg_y_d[0] = next_y_s;
                if (grow_eff_s && (length_q < 6'(MAX_LEN))) begin
                    length_d = length_q + 6'd1;
                end else begin
                    length_d = length_q;
                end
                grow_pend_d = 1'b0;
            end
        end else begin
            heading_d = heading_q;
        end
    end

    // Pixel-to-cell classification with HEAD > BODY > WALL > NONE priority.
    always_comb begin
        cell_x_s   = bus.pixel_x[9:4];
        cell_y_s   = bus.pixel_y[9:4];
        in_range_s = (bus.pixel_x < 10'd640) && (bus.pixel_y < 10'd480);
        head_pix_s = (cell_x_s == seg_x_q[0]) && (cell_y_s == {1'b0, seg_y_q[0]});
        body_pix_s = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            body_pix_s = body_pix_s | ((6'(i) < length_q) &&
                                       (cell_x_s == seg_x_q[i]) &&
                                       (cell_y_s == {1'b0, seg_y_q[i]}));
        end
`ifdef SNAKE_WRAP_EN
        wall_pix_s = 1'b0;
`else
        wall_pix_s = (cell_x_s == 6'd0) || (cell_x_s == 6'd39) ||
                     (cell_y_s == 6'd0) || (cell_y_s == 6'd29);
`endif
        if (!in_range_s) begin
            object_d = OBJ_NONE;
        end else if (head_pix_s) begin
            object_d = OBJ_HEAD;
        end else if (body_pix_s) begin
            object_d = OBJ_BODY;
        end else if (wall_pix_s) begin
            object_d = OBJ_WALL;
        end else begin
            object_d = OBJ_NONE;
        end
    end

    // State registers with synchronous reset to the initial three-segment snake.
    always_ff @(posedge clk_25mhz) begin
        if (rst) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= (i < 3) ? 6'(INIT_X - i) : 6'd0;
                seg_y_q[i] <= (i < 3) ? 5'(INIT_Y) : 5'd0;
            end
            length_q    <= 6'd3;
            heading_q   <= DIR_RIGHT;
            grow_pend_q <= 1'b0;
            dead_q      <= 1'b0;
            object_q    <= OBJ_NONE;
        end else begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= seg_x_d[i];
                seg_y_q[i] <= seg_y_d[i];
            end
            length_q    <= length_d;
            heading_q   <= heading_d;
            grow_pend_q <= grow_pend_d;
            dead_q      <= dead_d;
            object_q    <= object_d;
        end
    end

    assign bus.object = object_q;
    assign bus.head_x = seg_x_q[0];
    assign bus.head_y = seg_y_q[0];
    assign bus.length = length_q;
    assign bus.dead   = dead_q;

endmodule

// File: tb/tb_snake_object_module.sv
// Directed self-checking bench for snake_object_module (default MAX_LEN=16).
`timescale 1ns/1ps
module tb_snake_object_module;

    logic clk_25mhz = 1'b0;
    logic rst       = 1'b0;
    int   tests     = 0;
    int   fails     = 0;
    logic [1:0] obj;

    snake_object_module_if sif ();

    snake_object_module #(.MAX_LEN(16), .INIT_X(20), .INIT_Y(15)) dut (
        .clk_25mhz (clk_25mhz),
        .rst       (rst),
        .bus       (sif.slave)
    );

    always #20 clk_25mhz = ~clk_25mhz;

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sif.step = 1'b0;
        sif.grow = 1'b0;
        repeat (2) @(posedge clk_25mhz);
        #1;
        rst = 1'b0;
    endtask

    task automatic do_step(input logic [1:0] d, input logic g);
        sif.dir  = d;
        sif.grow = g;
        sif.step = 1'b1;
        @(posedge clk_25mhz);
        #1;
        sif.step = 1'b0;
        sif.grow = 1'b0;
    endtask

    task automatic probe(input logic [9:0] px, input logic [9:0] py, output logic [1:0] o);
        sif.pixel_x = px;
        sif.pixel_y = py;
        @(posedge clk_25mhz);
        #1;
        o = sif.object;
    endtask

    initial begin
        sif.pixel_x = 10'd0;
        sif.pixel_y = 10'd0;
        sif.step    = 1'b0;
        sif.dir     = 2'b11;
        sif.grow    = 1'b0;

        // Reset state and classification
        do_reset();
        check("rst_head_x", sif.head_x, 32'd20);
        check("rst_head_y", sif.head_y, 32'd15);
        check("rst_length", sif.length, 32'd3);
        check("rst_dead",   sif.dead,   32'd0);
        check("rst_object", sif.object, 32'd0);
        probe(10'd320, 10'd240, obj); check("obj_head", obj, 32'd1);
        probe(10'd300, 10'd240, obj); check("obj_body", obj, 32'd2);
        probe(10'd0,   10'd0,   obj);
`ifdef SNAKE_WRAP_EN
        check("obj_corner", obj, 32'd0);
`else
        check("obj_corner", obj, 32'd3);
`endif
        probe(10'd640, 10'd0,   obj); check("obj_x_range", obj, 32'd0);
        probe(10'd0,   10'd480, obj); check("obj_y_range", obj, 32'd0);
        probe(10'd100, 10'd100, obj); check("obj_empty", obj, 32'd0);

        // Move and reversal
        do_step(2'b11, 1'b0); check("mv_right_x", sif.head_x, 32'd21);
        do_step(2'b10, 1'b0); check("mv_rev_x", sif.head_x, 32'd22);
        check("mv_rev_y", sif.head_y, 32'd15);
        do_step(2'b00, 1'b0); check("mv_up_y", sif.head_y, 32'd14);
        check("mv_up_x", sif.head_x, 32'd22);
        check("mv_len", sif.length, 32'd3);

        // Grow coincident with step, tail stays put
        do_reset();
        do_step(2'b11, 1'b1);
        check("grow_len", sif.length, 32'd4);
        check("grow_head_x", sif.head_x, 32'd21);
        probe(10'd288, 10'd240, obj); check("grow_tail_body", obj, 32'd2);
        probe(10'd272, 10'd240, obj); check("grow_past_tail", obj, 32'd0);
        for (int i = 0; i < 12; i++) do_step(2'b11, 1'b1);
        check("grow_max_len", sif.length, 32'd16);
        check("grow_max_head", sif.head_x, 32'd33);
        do_step(2'b11, 1'b1);
        check("grow_at_max", sif.length, 32'd16);
        do_step(2'b11, 1'b0);
        check("grow_at_max2", sif.length, 32'd16);
        check("grow_at_max_hx", sif.head_x, 32'd35);

        // Grow alone then later step
        do_reset();
        sif.grow = 1'b1;
        @(posedge clk_25mhz); #1;
        sif.grow = 1'b0;
        check("pend_len_before", sif.length, 32'd3);
        do_step(2'b11, 1'b0);
        check("pend_len_after", sif.length, 32'd4);

        // Wall
        do_reset();
        for (int i = 0; i < 18; i++) do_step(2'b11, 1'b0);
        check("wall_hx38", sif.head_x, 32'd38);
        check("wall_alive", sif.dead, 32'd0);
        do_step(2'b11, 1'b0);
`ifdef SNAKE_WRAP_EN
        check("wrap_hx39", sif.head_x, 32'd39);
        check("wrap_alive", sif.dead, 32'd0);
        do_step(2'b11, 1'b0);
        check("wrap_hx0", sif.head_x, 32'd0);
        check("wrap_alive2", sif.dead, 32'd0);
        probe(10'd0, 10'd0, obj); check("wrap_no_wall", obj, 32'd0);
`else
        check("wall_dead", sif.dead, 32'd1);
        check("wall_hx_keep", sif.head_x, 32'd38);
        do_step(2'b00, 1'b1);
        check("dead_hx", sif.head_x, 32'd38);
        check("dead_hy", sif.head_y, 32'd15);
        check("dead_len", sif.length, 32'd3);
        check("dead_sticky", sif.dead, 32'd1);
        probe(10'd608, 10'd240, obj); check("dead_head_obj", obj, 32'd1);
`endif

        // Body collision
        do_reset();
        do_step(2'b11, 1'b1);
        do_step(2'b11, 1'b1);
        check("body_len5", sif.length, 32'd5);
        check("body_hx22", sif.head_x, 32'd22);
        do_step(2'b00, 1'b0);
        do_step(2'b10, 1'b0);
        check("body_hx21", sif.head_x, 32'd21);
        check("body_hy14", sif.head_y, 32'd14);
        do_step(2'b01, 1'b0);
        check("body_dead", sif.dead, 32'd1);
        check("body_hx_keep", sif.head_x, 32'd21);
        check("body_hy_keep", sif.head_y, 32'd14);

        // Tail chase in a 2x2 loop
        do_reset();
        do_step(2'b11, 1'b1);
        do_step(2'b00, 1'b0);
        do_step(2'b10, 1'b0);
        do_step(2'b01, 1'b0);
        do_step(2'b11, 1'b0);
        do_step(2'b00, 1'b0);
        check("chase_alive", sif.dead, 32'd0);
        check("chase_hx", sif.head_x, 32'd21);
        check("chase_hy", sif.head_y, 32'd14);
        // Tail is not vacated when growing, so chasing it now is fatal
        do_step(2'b10, 1'b1);
        check("chase_grow_dead", sif.dead, 32'd1);
        check("chase_grow_len", sif.length, 32'd4);
        check("chase_grow_hx", sif.head_x, 32'd21);

        // Reset overrides coincident step and grow
        do_step(2'b11, 1'b0);
        sif.step = 1'b1;
        sif.grow = 1'b1;
        sif.dir  = 2'b00;
        rst = 1'b1;
        @(posedge clk_25mhz); #1;
        rst = 1'b0;
        sif.step = 1'b0;
        sif.grow = 1'b0;
        check("rst_ovr_hx", sif.head_x, 32'd20);
        check("rst_ovr_hy", sif.head_y, 32'd15);
        check("rst_ovr_dead", sif.dead, 32'd0);
        do_step(2'b11, 1'b0);
        check("rst_ovr_len", sif.length, 32'd3);
        check("rst_ovr_step", sif.head_x, 32'd21);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
